// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch
// flushes, multi-cycle unit occupancy, a stall-cycle counter and a sticky md timeout.
module pipeline_hazard_ctrl #(
  parameter int MD_MAX_CYCLES = 64,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             uses_rs1_id,
  input  logic             uses_rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             mem_read_ex,
  input  logic             branch_taken_ex,
  input  logic             md_op_ex,
  input  logic             md_done,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic             bubble_mem,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WC_W = $clog2(MD_MAX_CYCLES + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MD_MAX_CYCLES);

  typedef enum logic {RUN, MD_WAIT} state_t;

  state_t          state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
  logic            timeout_nxt;
  logic            load_use;

  function automatic logic [WC_W-1:0] sat_inc_wait(input logic [WC_W-1:0] v);
    sat_inc_wait = (v >= WC_MAX) ? WC_MAX : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    sat_inc_cnt = (&v) ? v : v + 1'b1;
  endfunction

  assign load_use = mem_read_ex && (rd_ex != 5'd0) &&
                    ((uses_rs1_id && (rd_ex == rs1_id)) ||
                     (uses_rs2_id && (rd_ex == rs2_id)));

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    stall_ex     = 1'b0;
    flush_id     = 1'b0;
    bubble_ex    = 1'b0;
    bubble_mem   = 1'b0;
    md_start     = 1'b0;
    md_busy      = 1'b0;
    case (state)
      RUN: begin
        // A taken branch kills the ID instruction, so its hazards are moot.
        if (branch_taken_ex) begin
          flush_id  = 1'b1;
          bubble_ex = 1'b1;
        end else if (md_op_ex) begin
          md_start     = 1'b1;
          stall_if     = 1'b1;
          stall_id     = 1'b1;
          stall_ex     = 1'b1;
          bubble_mem   = 1'b1;
          state_nxt    = MD_WAIT;
          wait_cnt_nxt = '0;
        end else if (load_use) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
        end
      end
      MD_WAIT: begin
        md_busy = 1'b1;
        if (md_done) begin
          state_nxt = RUN;
        end else begin
          stall_if     = 1'b1;
          stall_id     = 1'b1;
          stall_ex     = 1'b1;
          bubble_mem   = 1'b1;
          wait_cnt_nxt = sat_inc_wait(wait_cnt);
        end
      end
      default: state_nxt = RUN;
    endcase
    timeout_nxt = md_timeout || ((state == MD_WAIT) && (wait_cnt_nxt == WC_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      wait_cnt     <= '0;
      md_timeout   <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      md_timeout <= timeout_nxt;
      if (stall_if) stall_cycles <= sat_inc_cnt(stall_cycles);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table plus hand-built md, timeout,
// reset-in-wait and counter saturation sequences, checked through a queue.
module tb_pipeline_hazard_ctrl;

  localparam int MDMAX = 8;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    rs1_id = '0, rs2_id = '0, rd_ex = '0;
  logic          uses_rs1_id = 1'b0, uses_rs2_id = 1'b0;
  logic          mem_read_ex = 1'b0, branch_taken_ex = 1'b0, md_op_ex = 1'b0, md_done = 1'b0;
  logic          stall_if, stall_id, stall_ex, flush_id, bubble_ex, bubble_mem;
  logic          md_start, md_busy, md_timeout;
  logic [CW-1:0] stall_cycles;

  pipeline_hazard_ctrl #(.MD_MAX_CYCLES(MDMAX), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id),
    .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex),
    .md_op_ex(md_op_ex), .md_done(md_done),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .flush_id(flush_id),
    .bubble_ex(bubble_ex), .bubble_mem(bubble_mem), .md_start(md_start), .md_busy(md_busy),
    .md_timeout(md_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Expected control bits: {stall_if,stall_id,stall_ex,flush_id,bubble_ex,bubble_mem,md_start,md_busy,md_timeout}
  localparam logic [8:0] NONE = 9'b000_000_000;
  localparam logic [8:0] LU   = 9'b110_010_000;
  localparam logic [8:0] BR   = 9'b000_110_000;
  localparam logic [8:0] MDS  = 9'b111_001_100;
  localparam logic [8:0] MDW  = 9'b111_001_010;
  localparam logic [8:0] MDD  = 9'b000_000_010;
  localparam logic [8:0] TO   = 9'b000_000_001;

  typedef struct {
    logic [4:0]    rs1, rs2, rd;
    logic          u1, u2, mr, br, md, done;
    logic [8:0]    ctrl;
    logic [CW-1:0] cnt;
  } vec_t;

  typedef struct {
    string         name;
    logic [8:0]    ctrl;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                              input logic u2, input logic [4:0] rd, input logic mr, input logic br,
                              input logic md, input logic done, input logic [8:0] ctrl,
                              input int cnt);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.mr = mr; v.br = br; v.md = md; v.done = done;
    v.ctrl = ctrl; v.cnt = CW'(cnt);
    return v;
  endfunction

  function automatic logic [8:0] actual_ctrl();
    return {stall_if, stall_id, stall_ex, flush_id, bubble_ex, bubble_mem, md_start, md_busy, md_timeout};
  endfunction

  task automatic check_head();
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    total++;
    if (actual_ctrl() !== e.ctrl) begin
      bad++;
      $display("FAIL %s ctrl: got %b want %b", e.name, actual_ctrl(), e.ctrl);
    end
    total++;
    if (stall_cycles !== e.cnt) begin
      bad++;
      $display("FAIL %s stall_cycles: got %0d want %0d", e.name, stall_cycles, e.cnt);
    end
  endtask

  // Drive one cycle's inputs just after the edge, compare mid-cycle.
  task automatic step(input string name, input vec_t v);
    exp_t e;
    @(posedge clk); #1;
    rs1_id = v.rs1; rs2_id = v.rs2; uses_rs1_id = v.u1; uses_rs2_id = v.u2;
    rd_ex = v.rd; mem_read_ex = v.mr; branch_taken_ex = v.br; md_op_ex = v.md; md_done = v.done;
    e.name = name; e.ctrl = v.ctrl; e.cnt = v.cnt;
    sb.push_back(e);
    #3;
    check_head();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rs1_id = '0; rs2_id = '0; uses_rs1_id = 0; uses_rs2_id = 0; rd_ex = '0;
    mem_read_ex = 0; branch_taken_ex = 0; md_op_ex = 0; md_done = 0;
    rst_n = 1'b0;
    #2;
    sb.push_back('{"reset", NONE, CW'(0)});
    check_head();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  vec_t tbl[$];
  vec_t idle, lu, mdw, mdd;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0);

    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0));  // idle
    tbl.push_back(mk(5, 0, 1, 0, 5, 1, 0, 0, 0, LU,   0));  // load-use rs1
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 1));  // single cycle stall
    tbl.push_back(mk(3, 7, 1, 1, 7, 1, 0, 0, 0, LU,   1));  // load-use rs2
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, NONE, 2));  // rd=0 never stalls
    tbl.push_back(mk(5, 5, 0, 0, 5, 1, 0, 0, 0, NONE, 2));  // match but regs unused
    tbl.push_back(mk(5, 0, 1, 0, 5, 0, 0, 0, 0, NONE, 2));  // match but not a load
    tbl.push_back(mk(5, 0, 1, 0, 5, 1, 1, 0, 0, BR,   2));  // branch beats load-use
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 2));  // counter unchanged
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, BR,   2));  // branch beats md_op
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, NONE, 2));  // md_done in RUN ignored

    do_reset();
    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

    // md op with md_done four cycles after md_start, then a back-to-back op.
    do_reset();
    mdw = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MDW, 0);
    mdd = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, MDD, 0);
    step("md_start", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MDS, 0));
    for (int k = 1; k <= 3; k++) begin
      mdw.cnt = CW'(k);
      step($sformatf("md_wait%0d", k), mdw);
    end
    mdd.cnt = CW'(4);
    step("md_done", mdd);
    step("md_b2b_start", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MDS, 4));
    mdd.cnt = CW'(5);
    step("md_b2b_done", mdd);
    step("md_after", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 5));

    // Timeout: md_done low for 12 wait cycles.
    do_reset();
    step("to_start", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MDS, 0));
    for (int k = 1; k <= 12; k++) begin
      mdw = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MDW | ((k - 1 >= MDMAX) ? TO : NONE), k);
      step($sformatf("to_wait%0d", k), mdw);
    end
    step("to_done", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, MDD | TO, 13));
    step("to_run", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, TO, 13));
    step("to_sticky", mk(5, 0, 1, 0, 5, 1, 0, 0, 0, LU | TO, 13));

    // Reset asserted two cycles into MD_WAIT.
    do_reset();
    step("rw_start", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MDS, 0));
    step("rw_wait1", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MDW, 1));
    step("rw_wait2", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MDW, 2));
    @(negedge clk);
    md_op_ex = 0;
    rst_n = 1'b0;
    #1;
    sb.push_back('{"reset_mid_wait", NONE, CW'(0)});
    check_head();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("rw_after", idle);

    // Continuous load-use saturates the counter.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      lu = mk(9, 0, 1, 0, 9, 1, 0, 0, 0, LU, (k > 15) ? 15 : k);
      step($sformatf("sat%0d", k), lu);
    end
    step("sat_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 15));

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
